servisia_uart_tx: RTL and testbench

//   Wishbone transmit-only UART peripheral on the subservient core's peripheral bus (o_wb_*/i_wb_*).

---
 rtl/servisia_uart_pkg.sv | 41 ++++
 rtl/servisia_fifo.sv | 71 +++++++
 rtl/servisia_uart_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_servisia_uart_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servisia_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : servisia_uart_pkg
// Brief   : Shared constants and types for the servisia transmit UART:
//           serialiser state encoding, register map, STATUS bit layout,
//           frame geometry and the divisor clamp helper.
// Revision: 1.0 - initial release
// ============================================================================
package servisia_uart_pkg;

  // Serialiser states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Register select values (core address bit 2)
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_DIV  = 1'b1;

  // STATUS register layout
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

  // 8N1 frame geometry
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

  // Divisor values 0 and 1 both mean one clock per bit
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < 16'd2) ? 16'd1 : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servisia_fifo.sv
`default_nettype none
// ============================================================================
// Module  : servisia_fifo
// Brief   : Small synchronous show-ahead FIFO. rdata always presents the
//           oldest entry; push is ignored when full, pop ignored when empty.
//           Full/empty/count come straight from registered state.
// Revision: 1.0 - initial release
// ============================================================================
module servisia_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array: data only, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/servisia_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : servisia_uart_tx
// Brief   : Wishbone transmit-only UART. Bytes written to DATA are queued in
//           a small FIFO and serialised 8N1 on tx_o, LSB first, at a bit
//           period set by the DIV register. STATUS exposes FIFO state.
// Revision: 1.0 - initial release
// ============================================================================
module servisia_uart_tx
  import servisia_uart_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_rdt_o,
  output logic        wb_ack_o,
  output logic        tx_o
);

  // ------------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------------
  logic                   r_ack;
  logic [31:0]            r_rdt;
  logic [15:0]            r_div;

  tx_state_e              r_state;
  tx_state_e              w_state_nxt;
  logic [15:0]            r_cnt;
  logic [15:0]            w_cnt_nxt;
  logic [15:0]            r_bit_div;
  logic [15:0]            w_bit_div_nxt;
  logic [7:0]             r_shift;
  logic [7:0]             w_shift_nxt;
  logic [2:0]             r_idx;
  logic [2:0]             w_idx_nxt;

  logic                   w_data_wr;
  logic                   w_stall;
  logic                   w_ack_set;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_div_wr;
  logic                   w_bit_end;
  logic                   w_busy;
  logic                   w_tx;
  logic [31:0]            w_status;
  logic [31:0]            w_rd_data;

  logic [7:0]             w_fifo_rdata;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;

  // Upper data lanes and byte enables carry nothing for this peripheral
  logic                   w_unused;
  assign w_unused = &{1'b0, wb_dat_i[31:16], wb_sel_i[3:2]};

  // ------------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------------
  assign w_data_wr = wb_we_i & (wb_adr_i == REG_DATA) & wb_sel_i[0];
  // A DATA write into a full FIFO waits here rather than being dropped
  assign w_stall   = w_data_wr & w_fifo_full;
  assign w_ack_set = wb_stb_i & ~r_ack & ~w_stall;
  assign w_push    = w_ack_set & w_data_wr;
  assign w_div_wr  = w_ack_set & wb_we_i & (wb_adr_i == REG_DIV);
  assign w_busy    = (r_state != ST_IDLE) | ~w_fifo_empty;

  // STATUS word assembly
  always_comb begin
    w_status                                    = '0;
    w_status[STAT_FULL]                         = w_fifo_full;
    w_status[STAT_EMPTY]                        = w_fifo_empty;
    w_status[STAT_BUSY]                         = w_busy;
    w_status[STAT_COUNT_LSB +: STAT_COUNT_W]    = STAT_COUNT_W'(w_fifo_count);
  end

  assign w_rd_data = (wb_adr_i == REG_DIV) ? {16'd0, r_div} : w_status;

  // Single-cycle ack; read data is only non-zero alongside ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= w_ack_set;
      r_rdt <= (w_ack_set & ~wb_we_i) ? w_rd_data : 32'd0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_rdt_o = r_rdt;

  // Divisor register with per-byte enables
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div <= DIV_RESET;
    end else if (w_div_wr) begin
      if (wb_sel_i[0]) begin
        r_div[7:0] <= wb_dat_i[7:0];
      end
      if (wb_sel_i[1]) begin
        r_div[15:8] <= wb_dat_i[15:8];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Transmit FIFO
  // ------------------------------------------------------------------------
  servisia_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_wdata (wb_dat_i[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // ------------------------------------------------------------------------
  // Serialiser
  // ------------------------------------------------------------------------
  // r_bit_div is captured at each bit boundary so a DIV write never
  // disturbs the bit currently on the line.
  assign w_bit_end = (r_cnt == (r_bit_div - 16'd1));

  // Serialiser state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_div <= eff_div(DIV_RESET);
      r_shift   <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_div <= w_bit_div_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
    end
  end

  // Serialiser next-state, FIFO pop and line level
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 16'd1;
    w_bit_div_nxt = r_bit_div;
    w_shift_nxt   = r_shift;
    w_idx_nxt     = r_idx;
    w_pop         = 1'b0;
    w_tx          = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_tx      = 1'b1;
        w_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_rdata;
          w_bit_div_nxt = eff_div(r_div);
          w_state_nxt   = ST_START;
        end
      end

      ST_START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_bit_div_nxt = eff_div(r_div);
          w_idx_nxt     = '0;
          w_state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_bit_div_nxt = eff_div(r_div);
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          if (r_idx == 3'(DATA_BITS - 1)) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end

      ST_STOP: begin
        w_tx = 1'b1;
        if (w_bit_end) begin
          w_cnt_nxt     = '0;
          w_bit_div_nxt = eff_div(r_div);
          // Chain straight into the next start bit when more data waits
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_rdata;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign tx_o = w_tx;

endmodule
`default_nettype wire

// File: tb/tb_servisia_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_servisia_uart_tx
// Brief   : Self-checking bench for servisia_uart_tx. Accepted DATA writes
//           are queued as expected bytes; a line monitor decodes frames on
//           tx_o and compares them against the queue. Directed checks cover
//           reset, ack timing, waveforms, stall, divisor and ignored writes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_servisia_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_adr = 1'b0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        tx;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  sb_q [$];
  bit          mon_en = 1'b0;
  int          mon_div = 4;

  servisia_uart_tx #(
    .DEPTH     (4),
    .DIV_RESET (16'd868)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_stb_i (wb_stb),
    .wb_rdt_o (wb_rdt),
    .wb_ack_o (wb_ack),
    .tx_o     (tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic adr, input logic [31:0] dat, input logic [3:0] sel,
                          output int waits);
    if (wb_ack) @(posedge clk);
    @(negedge clk);
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (wb_ack !== 1'b1 && waits < 2000);
    if (wb_ack !== 1'b1) check_eq("wr_ack_timeout", waits, 0);
    wb_stb = 1'b0; wb_we = 1'b0;
    if (wb_ack === 1'b1 && mon_en && adr == 1'b0 && sel[0]) sb_q.push_back(dat[7:0]);
  endtask

  task automatic wb_read(input logic adr, output logic [31:0] data, output int waits);
    if (wb_ack) @(posedge clk);
    @(negedge clk);
    wb_adr = adr; wb_sel = 4'b1111; wb_we = 1'b0; wb_stb = 1'b1;
    waits = 0;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (wb_ack !== 1'b1 && waits < 2000);
    if (wb_ack !== 1'b1) check_eq("rd_ack_timeout", waits, 0);
    data = wb_rdt;
    wb_stb = 1'b0;
  endtask

  // Walk one frame cycle by cycle; the first `skip` cycles have already passed
  task automatic expect_frame(input string tag, input logic [7:0] b, input int d0, input int d1,
                              input bit chk_ack, input int skip);
    int errs = 0;
    int idx = 0;
    for (int i = 0; i < 10; i++) begin
      logic v;
      int   dur;
      v   = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      dur = (i == 0) ? d0 : d1;
      for (int c = 0; c < dur; c++) begin
        if (idx >= skip) begin
          @(negedge clk);
          if (tx !== v) errs++;
          if (chk_ack && wb_ack !== 1'b0) errs++;
        end
        idx++;
      end
    end
    check_eq(tag, errs, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check_eq(tag, sb_q.size(), 0);
    repeat (20) @(posedge clk);
  endtask

  // Line monitor: decode frames at mid-bit and score them
  initial begin : mon
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        int         d;
        int         pos;
        logic [9:0] fr;
        logic [7:0] ex;
        d   = mon_div;
        pos = 0;
        fr  = '0;
        for (int i = 0; i < 10; i++) begin
          while (pos < d * i + d / 2) begin
            @(negedge clk);
            pos++;
          end
          fr[i] = tx;
        end
        if (sb_q.size() == 0) begin
          check_eq("mon_unexpected_frame", {22'd0, fr}, 32'd0);
        end else begin
          ex = sb_q.pop_front();
          check_eq("mon_frame", {22'd0, fr}, {22'd0, 1'b1, ex, 1'b0});
        end
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #1_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          w;
    logic [31:0] rd;
    int          errs;
    logic [7:0]  stall_bytes [6];

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_outputs", {29'd0, tx, wb_ack, |wb_rdt}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    wb_read(1'b0, rd, w);
    check_eq("rst_status", rd, 32'h0000_0002);
    wb_read(1'b1, rd, w);
    check_eq("rst_div", rd, 32'h0000_0364);

    // Test 1: reset mid-frame
    mon_en = 1'b0;
    wb_write(1'b1, 32'h0000_0004, 4'b0011, w);
    wb_write(1'b0, 32'h0000_0080, 4'b0001, w);
    wb_write(1'b0, 32'h0000_0042, 4'b0001, w);
    repeat (6) @(posedge clk);
    #2;
    check_eq("t1_pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("t1_rst_async", {29'd0, tx, wb_ack, |wb_rdt}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    wb_read(1'b0, rd, w);
    check_eq("t1_status", rd, 32'h0000_0002);
    wb_read(1'b1, rd, w);
    check_eq("t1_div_reset", rd, 32'h0000_0364);

    // Test 2: single byte waveform and ack timing
    mon_en = 1'b1;
    mon_div = 4;
    wb_write(1'b1, 32'h0000_0004, 4'b0011, w);
    check_eq("t2_div_wr_wait", w, 1);
    wb_read(1'b1, rd, w);
    check_eq("t2_div_rd", rd, 32'h0000_0004);
    check_eq("t2_div_rd_wait", w, 1);
    wb_write(1'b0, 32'hABCD_EF55, 4'b1111, w);
    check_eq("t2_data_wr_wait", w, 1);
    @(negedge clk);
    check_eq("t2_t1_tx_ack", {30'd0, tx, wb_ack}, {30'd0, 1'b1, 1'b1});
    expect_frame("t2_frame", 8'h55, 4, 4, 1'b1, 0);
    wb_read(1'b0, rd, w);
    check_eq("t2_status_idle", rd, 32'h0000_0002);
    wait_drain("t2_drain");

    // Test 3: back-to-back frames with no idle gap
    wb_write(1'b0, 32'h0000_00A5, 4'b0001, w);
    wb_write(1'b0, 32'h0000_003C, 4'b0001, w);
    expect_frame("t3_frame1", 8'hA5, 4, 4, 1'b0, 1);
    expect_frame("t3_frame2", 8'h3C, 4, 4, 1'b0, 0);
    wait_drain("t3_drain");

    // Test 4: full-FIFO stall
    wb_write(1'b1, 32'h0000_0010, 4'b0011, w);
    mon_div = 16;
    stall_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int k = 0; k < 6; k++) begin
      wb_write(1'b0, {24'd0, stall_bytes[k]}, 4'b0001, w);
      check_eq($sformatf("t4_wr%0d_wait", k + 1), w, (k < 5) ? 1 : 153);
    end
    wb_read(1'b0, rd, w);
    check_eq("t4_status_full", rd, 32'h0000_0405);
    wait_drain("t4_drain");

    // Test 5: divisor byte enables, div=0, mid-frame change
    wb_write(1'b1, 32'h0000_0002, 4'b0001, w);
    wb_read(1'b1, rd, w);
    check_eq("t5_div_sel0", rd, 32'h0000_0002);
    wb_write(1'b1, 32'h0000_0000, 4'b0011, w);
    wb_read(1'b1, rd, w);
    check_eq("t5_div_zero", rd, 32'h0000_0000);
    mon_div = 1;
    wb_write(1'b0, 32'h0000_0096, 4'b0001, w);
    @(negedge clk);
    check_eq("t5_div0_idle", {31'd0, tx}, 32'd1);
    expect_frame("t5_div0_frame", 8'h96, 1, 1, 1'b1, 0);
    wait_drain("t5_div0_drain");
    mon_en = 1'b0;
    wb_write(1'b1, 32'h0000_0004, 4'b0011, w);
    wb_write(1'b0, 32'h0000_000F, 4'b0001, w);
    wb_write(1'b1, 32'h0000_0002, 4'b0011, w);
    expect_frame("t5_midchange", 8'h0F, 4, 2, 1'b0, 1);
    repeat (10) @(posedge clk);

    // Test 6: DATA write with sel[0]=0 is acked and ignored
    mon_en = 1'b1;
    mon_div = 2;
    wb_write(1'b0, 32'h0000_0077, 4'b0010, w);
    check_eq("t6_ack_wait", w, 1);
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) errs++;
      if (!wb_ack && wb_rdt !== 32'd0) errs++;
    end
    check_eq("t6_line_idle", errs, 0);
    wb_read(1'b0, rd, w);
    check_eq("t6_status", rd, 32'h0000_0002);

    wait_drain("final_drain");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
